// File: rtl/sim_trig_pkg.sv
// Shared types and constants for the simulation frame trigger.
package sim_trig_pkg;

  typedef enum logic [1:0] {
    WAIT_DL = 2'd0,
    ARMED   = 2'd1,
    DUMP    = 2'd2,
    DONE    = 2'd3
  } trig_state_e;

  localparam int SYNC_STAGES = 2;

  // Without download gating the trigger is armed straight out of reset.
  function automatic trig_state_e reset_state(input int wait_dwnld);
    return (wait_dwnld != 0) ? WAIT_DL : ARMED;
  endfunction

endpackage

// File: rtl/sim_frame_trigger_if.sv
// Bundle between the frame trigger and the waveform-dump controller.
interface sim_frame_trigger_if #(
  parameter int CNT_W = 32
);
  logic             vs;
  logic             downloading;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_tick;
  logic             dump_on;
  logic             dump_start;
  logic             dump_stop;
  logic [CNT_W-1:0] frame_period;

  modport master (
    input  vs,
    input  downloading,
    output frame_cnt,
    output frame_tick,
    output dump_on,
    output dump_start,
    output dump_stop,
    output frame_period
  );

  modport slave (
    output vs,
    output downloading,
    input  frame_cnt,
    input  frame_tick,
    input  dump_on,
    input  dump_start,
    input  dump_stop,
    input  frame_period
  );
endinterface

// File: rtl/sim_edge_sync.sv
// Multi-flop synchronizer with a delayed copy for single-cycle rise/fall pulses.
module sim_edge_sync
  import sim_trig_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/sim_frame_trigger.sv
// Frame counter and dump-window generator driven by vsync and the download flag.
// Define SIM_FRAME_PERIOD_EN to measure clk cycles between frame ticks on frame_period.
module sim_frame_trigger
  import sim_trig_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int START_FRAME = 0,
  parameter int DUMP_FRAMES = 0,
  parameter int WAIT_DWNLD  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sim_frame_trigger_if.master trig
);

  localparam trig_state_e      RST_STATE = reset_state(WAIT_DWNLD);
  localparam logic [CNT_W-1:0] START_VAL = CNT_W'(START_FRAME);
  localparam logic [CNT_W-1:0] DUMP_VAL  = CNT_W'(DUMP_FRAMES);

  logic vs_fall;
  logic vs_rise_unused;
  logic vs_level_unused;
  logic dl_rise;
  logic dl_fall;
  logic dl_level_unused;

  sim_edge_sync u_vs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (trig.vs),
    .level_o (vs_level_unused),
    .rise_o  (vs_rise_unused),
    .fall_o  (vs_fall)
  );

  sim_edge_sync u_dl_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (trig.downloading),
    .level_o (dl_level_unused),
    .rise_o  (dl_rise),
    .fall_o  (dl_fall)
  );

  trig_state_e      state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             dump_on_q;
  logic             dump_start_q, dump_start_d;
  logic             dump_stop_q, dump_stop_d;

  // A download ending restarts the count even if a frame lands in the same cycle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (dl_fall) begin
      frame_cnt_d = '0;
    end else if (vs_fall) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    dump_start_d = 1'b0;
    dump_stop_d  = 1'b0;
    if (dl_rise && (state_q != WAIT_DL)) begin
      state_d     = WAIT_DL;
      dump_stop_d = (state_q == DUMP);
    end else begin
      case (state_q)
        WAIT_DL: begin
          if (dl_fall) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if ((START_FRAME == 0) || (vs_fall && (frame_cnt_d == START_VAL))) begin
            state_d      = DUMP;
            dump_start_d = 1'b1;
            win_d        = '0;
          end
        end
        DUMP: begin
          if (vs_fall) begin
            win_d = win_q + CNT_W'(1);
            if ((DUMP_FRAMES != 0) && (win_d == DUMP_VAL)) begin
              state_d     = DONE;
              dump_stop_d = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = RST_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      frame_cnt_q  <= '0;
      win_q        <= '0;
      dump_on_q    <= 1'b0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      win_q        <= win_d;
      dump_on_q    <= (state_d == DUMP);
      dump_start_q <= dump_start_d;
      dump_stop_q  <= dump_stop_d;
    end
  end

`ifdef SIM_FRAME_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;

  // Counter saturates so a stalled vsync reports all-ones rather than wrapping.
  always_comb begin
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    if (vs_fall) begin
      period_d  = per_cnt_q;
      per_cnt_d = CNT_W'(1);
    end else if (per_cnt_q != '1) begin
      per_cnt_d = per_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
      period_q  <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
    end
  end

  assign trig.frame_period = period_q;
`else
  assign trig.frame_period = '0;
`endif

  assign trig.frame_cnt  = frame_cnt_q;
  assign trig.frame_tick = vs_fall;
  assign trig.dump_on    = dump_on_q;
  assign trig.dump_start = dump_start_q;
  assign trig.dump_stop  = dump_stop_q;

  a_start_stop_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(dump_start_q && dump_stop_q)
  );

  a_on_tracks_state : assert property (
    @(posedge clk) disable iff (!rst_n) dump_on_q == (state_q == DUMP)
  );

endmodule
